// File: rtl/seg_pkg.sv
// seg_pkg: shared segment codes (CX[7:1] = a..g, active-low), blank pattern and scan FSM state encoding
package seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {ST_DRIVE = 1'b0, ST_BLANK = 1'b1} state_t;
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: hex nibble (hex) to active-low a..g segment pattern (seg)
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_CODES[hex];
endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 8-digit multiplexed 7-seg scanner; load_valid/load_ready frame handshake in, registered active-low AN/CX and frame_done out
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int CLK_PER_DIGIT = 100_000,
  parameter int BLANK_CYCLES  = 1_000
) (
  input  logic        clk,
  input  logic        Resetn,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  output logic [7:0]  AN,
  output logic [7:0]  CX,
  output logic        frame_done
);
  localparam int MAXC = CLK_PER_DIGIT > BLANK_CYCLES ? CLK_PER_DIGIT : BLANK_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [31:0] pend_digits, act_digits;
  logic [7:0] pend_dp, pend_en, act_dp, act_en, an_n, cx_n;
  logic pending_full, last, boundary, show;
  logic [6:0] seg;
  hex_to_seg u_hex (.hex(act_digits[{idx, 2'b00} +: 4]), .seg(seg));
  assign load_ready = !pending_full;
  always_comb begin
    last = cnt == W'(state == ST_DRIVE ? CLK_PER_DIGIT - 1 : BLANK_CYCLES - 1);
    boundary = state == ST_BLANK && last && idx == 3'd7;
    state_n = last ? (state == ST_DRIVE ? ST_BLANK : ST_DRIVE) : state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = state == ST_BLANK && last ? idx + 3'd1 : idx;
    show = state == ST_DRIVE && act_en[idx];
    an_n = show ? ~(8'd1 << idx) : SEG_BLANK;
    cx_n = show ? {seg, ~act_dp[idx]} : SEG_BLANK;
  end
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_BLANK;
      cnt <= '0;
      idx <= 3'd7;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      AN <= SEG_BLANK;
      CX <= SEG_BLANK;
      frame_done <= 1'b0;
      pending_full <= 1'b0;
      pend_digits <= '0;
      pend_dp <= '0;
      pend_en <= '0;
      act_digits <= '0;
      act_dp <= '0;
      act_en <= '0;
    end else begin
      AN <= an_n;
      CX <= cx_n;
      frame_done <= boundary;
      if (boundary && pending_full) begin
        act_digits <= pend_digits;
        act_dp <= pend_dp;
        act_en <= pend_en;
        pending_full <= 1'b0;
      end else if (load_valid && !pending_full) begin
        pend_digits <= digits;
        pend_dp <= dp;
        pend_en <= digit_en;
        pending_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: randomized directed bench checking the scanner against a cycle-index schedule model
module tb_seg_scan_controller;
  localparam int CPD = 4, BC = 1, P = CPD + BC, F = 8 * P;
  logic clk = 1'b0, Resetn = 1'b1, load_valid = 1'b0, load_ready, frame_done;
  logic [31:0] digits = '0;
  logic [7:0] dp = '0, digit_en = '0, AN, CX;
  int errors = 0, checks = 0, k = 0;
  logic m_full = 1'b0;
  logic [31:0] m_pd = '0, m_ad = '0;
  logic [7:0] m_pdp = '0, m_adp = '0, m_pen = '0, m_aen = '0;
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  always #5 clk = ~clk;
  seg_scan_controller #(.CLK_PER_DIGIT(CPD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .Resetn(Resetn), .load_valid(load_valid), .load_ready(load_ready),
    .digits(digits), .dp(dp), .digit_en(digit_en), .AN(AN), .CX(CX), .frame_done(frame_done)
  );
  function automatic int digit_of(int kk);
    return kk < BC ? -1 : ((kk - BC) % F) / P;
  endfunction
  function automatic bit driving(int kk);
    return kk >= BC && ((kk - BC) % P) < CPD;
  endfunction
  function automatic bit is_boundary(int kk);
    return kk >= BC - 1 && ((kk - (BC - 1)) % F) == 0;
  endfunction
  function automatic logic [15:0] expect_out(int kk);
    int d;
    d = digit_of(kk);
    if (!driving(kk) || !m_aen[d]) return 16'hFFFF;
    return {~(8'd1 << d), seg_tab[m_ad[4*d +: 4]], ~m_adp[d]};
  endfunction
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask
  task automatic rst_model();
    k = 0;
    m_full = 1'b0;
    m_ad = '0;
    m_adp = '0;
    m_aen = '0;
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    logic [15:0] eo;
    logic eb;
    load_valid = v;
    digits = d;
    dp = p;
    digit_en = e;
    eo = expect_out(k);
    eb = is_boundary(k);
    @(posedge clk);
    if (eb && m_full) begin
      m_ad = m_pd;
      m_adp = m_pdp;
      m_aen = m_pen;
      m_full = 1'b0;
    end else if (v && !m_full) begin
      m_pd = d;
      m_pdp = p;
      m_pen = e;
      m_full = 1'b1;
    end
    k++;
    #1;
    check("AN", {8'h0, AN}, {8'h0, eo[15:8]});
    check("CX", {8'h0, CX}, {8'h0, eo[7:0]});
    check("frame_done", {15'h0, frame_done}, {15'h0, eb});
    check("load_ready", {15'h0, load_ready}, {15'h0, !m_full});
    check("an_onehot", 16'($countones(~AN) <= 1), 16'd1);
  endtask
  task automatic run(input int n, input logic v);
    for (int i = 0; i < n; i++) step(v, $urandom, 8'($urandom), 8'($urandom));
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_AN"}, {8'h0, AN}, 16'h00FF);
    check({tag, "_CX"}, {8'h0, CX}, 16'h00FF);
    check({tag, "_ready"}, {15'h0, load_ready}, 16'd1);
    check({tag, "_done"}, {15'h0, frame_done}, 16'd0);
  endtask
  initial begin
    #1 Resetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    rst_model();
    step(1'b1, 32'h76543210, 8'h00, 8'hFF);
    run(3 * F, 1'b0);
    run(4 * F, 1'b1);
    run(F, 1'b0);
    step(1'b1, $urandom, 8'($urandom), 8'b10101010);
    run(2 * F, 1'b0);
    step(1'b1, 32'h0000000F | ($urandom & 32'hFFFFFFF0), 8'h01, 8'hFF);
    run(2 * F, 1'b0);
    for (int i = 0; i < F && !(is_boundary(k) && !m_full); i++) run(1, 1'b0);
    step(1'b1, 32'h89ABCDEF, 8'h5A, 8'hFF);
    run(2 * F, 1'b0);
    for (int i = 0; i < F && digit_of(k) != 1; i++) run(1, 1'b0);
    step(1'b1, 32'hFEDCBA98, 8'hFF, 8'hFF);
    for (int i = 0; i < F && !(digit_of(k) == 5 && driving(k)); i++) run(1, 1'b0);
    check("reach_digit5", {15'h0, driving(k) && digit_of(k) == 5}, 16'd1);
    Resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    Resetn = 1'b1;
    rst_model();
    run(2 * F, 1'b0);
    step(1'b1, 32'h76543210, 8'h08, 8'hFF);
    run(2 * F, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter CLK_PER_DIGIT, default 100_000: clk cycles each digit is driven; legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 1_000: all-off guard cycles between digits; legal range >= 1.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  new display frame offered.
REQ-006 load_ready  output  1  pending buffer empty; frame can be accepted.
REQ-007 digits  input  32  eight hex nibbles; nibble i = digits[4i+3:4i] drives digit i.
REQ-008 dp  input  8  decimal point per digit, 1 = lit.
REQ-009 digit_en  input  8  per-digit enable, 1 = shown.
REQ-010 AN  output  8  digit anodes, active-low, registered.
REQ-011 CX  output  8  segments, active-low, registered; CX[7:1] = a..g, CX[0] = dp.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Handshake: transfer occurs on a posedge with load_valid && load_ready; digits, dp and digit_en are captured into the pending buffer; pending_full is set.
REQ-014 load_ready SHALL equal !pending_full; while pending_full, load_valid is ignored and inputs are not sampled.
REQ-015 Active buffer (digits/dp/en) SHALL change only at a frame boundary, never mid-frame.
REQ-016 FSM states DRIVE and BLANK; per-state down/up counter, width $clog2(max(CLK_PER_DIGIT, BLANK_CYCLES)+1).
REQ-017 DRIVE lasts exactly CLK_PER_DIGIT cycles for digit idx, then BLANK.
REQ-018 BLANK lasts exactly BLANK_CYCLES cycles; then idx = (idx+1) mod 8, then DRIVE.
REQ-019 Frame boundary = last BLANK cycle with idx = 7: frame_done pulses for the next cycle; if pending_full, active <= pending and pending_full clears.
REQ-020 Same-cycle handshake and boundary: pending was empty, so nothing is copied; the new data stays pending until the next boundary.
REQ-021 During DRIVE of idx with active_en[idx] = 1: AN = ~(8'b1 << idx); CX[7:1] = hex-to-segment code of nibble idx; CX[0] = ~active_dp[idx].
REQ-022 During BLANK, or DRIVE of a disabled digit: AN = 8'hFF, CX = 8'hFF.
REQ-023 AN/CX SHALL reflect the state one cycle after the state register: registered outputs with 1-cycle latency.
REQ-024 Segment codes, CX[7:1]: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-025 At most one AN bit SHALL be low in any cycle.

Reset
REQ-026 Resetn low SHALL immediately force: AN = 8'hFF, CX = 8'hFF, frame_done = 0, load_ready = 1, pending_full = 0, active buffer = 0 (all digits disabled), state = BLANK, idx = 7, counter = 0.
REQ-027 After Resetn deasserts, the first boundary occurs after BLANK_CYCLES cycles (frame_done pulses); digit 0 DRIVE follows.
REQ-028 Reset mid-frame or mid-handshake SHALL discard pending and active data; no partial frame is displayed.

Structure
REQ-029 Shared package seg_pkg SHALL hold the 16 segment codes, the blank constant 8'hFF and the FSM state encoding.
REQ-030 One combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out), SHALL be instantiated once on the muxed active nibble.

Verification (CLK_PER_DIGIT = 4, BLANK_CYCLES = 1; frame = 40 cycles)
REQ-031 Reset, then load digits = 32'h76543210, dp = 0, en = 8'hFF before the first boundary -> from the next frame, digit i shows i for 4 cycles with AN = ~(1<<i); digit 3 gives CX = 8'b00001101.
REQ-032 Hold load_valid high continuously -> one transfer per frame; load_ready low from acceptance until the boundary; active data never changes mid-frame.
REQ-033 en = 8'b10101010 -> AN = 8'hFF during digit 0/2/4/6 slots; 1-cycle all-off gaps between every digit; never two AN bits low.
REQ-034 Handshake on the exact boundary cycle -> data appears one frame later; frame_done pulses every 40 cycles.
REQ-035 Assert Resetn low mid-DRIVE of digit 5 -> AN = CX = 8'hFF immediately; load_ready = 1; after release, frame_done at cycle BLANK_CYCLES and display blank until a new load.
REQ-036 dp = 8'h01, digit 0 = 4'hF -> CX = 8'b01110000 on the digit 0 slot.
